mips_multicycle_ctrl: RTL and testbench

//  Multicycle MIPS main controller. Sequences the shared datapath (PC, memory port, register file,
//  ALU, immediate extender) one instruction at a time. Selects sign- vs zero-extension of the
//  16-bit immediate and waits on a ready handshake from the memory port.

---
 rtl/mips_multicycle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: Moore FSM sequencing the shared datapath,
// with a bounded wait on the memory ready handshake.
//
// state   | meaning
// FETCH   | read instruction at PC, load IR and PC+4 on mem_ready
// DECODE  | branch target into ALUOut, dispatch on opcode
// MEMADR  | compute load/store address
// MEMRD   | data read, wait on mem_ready
// MEMWB   | load data written to rt
// MEMWR   | data write, wait on mem_ready
// RTYPEEX | ALU op selected by funct
// RTYPEWB | ALUOut written to rd
// BEQEX   | compare rs/rt, load PC from ALUOut if equal
// IEX     | ALU op with extended immediate
// IWB     | ALUOut written to rt
// JEX     | load PC with jump target
module mips_multicycle_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int OPW      = 6
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic [OPW-1:0] i_op,
  input  logic [OPW-1:0] i_funct,
  input  logic           i_zero,
  input  logic           i_mem_ready,
  output logic           o_pcwrite,
  output logic           o_irwrite,
  output logic           o_memread,
  output logic           o_memwrite,
  output logic           o_iord,
  output logic           o_regwrite,
  output logic           o_regdst,
  output logic           o_memtoreg,
  output logic           o_alusrca,
  output logic [1:0]     o_alusrcb,
  output logic [1:0]     o_pcsrc,
  output logic [2:0]     o_alucontrol,
  output logic           o_ext_zero,
  output logic           o_illegal,
  output logic           o_bus_err
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_IEX, S_IWB, S_JEX
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [7:0]     WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     r_state, w_next;
  logic [7:0] r_wait;
  logic       r_illegal, r_bus_err;
  logic       w_wait_st, w_timeout, w_ill_set;
  logic       w_pcwrite, w_irwrite, w_memread, w_memwrite, w_iord;
  logic       w_regwrite, w_regdst, w_memtoreg, w_alusrca, w_ext_zero;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_alucontrol;

  always_comb begin
    w_next       = r_state;
    w_wait_st    = 1'b0;
    w_timeout    = 1'b0;
    w_ill_set    = 1'b0;
    w_pcwrite    = 1'b0;
    w_irwrite    = 1'b0;
    w_memread    = 1'b0;
    w_memwrite   = 1'b0;
    w_iord       = 1'b0;
    w_regwrite   = 1'b0;
    w_regdst     = 1'b0;
    w_memtoreg   = 1'b0;
    w_alusrca    = 1'b0;
    w_ext_zero   = 1'b0;
    w_alusrcb    = 2'b00;
    w_pcsrc      = 2'b00;
    w_alucontrol = 3'b010;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        w_wait_st = 1'b1;
        if (i_mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (i_op)
          OP_LW, OP_SW:             w_next = S_MEMADR;
          OP_RTYPE:                 w_next = S_RTYPEEX;
          OP_BEQ:                   w_next = S_BEQEX;
          OP_ADDI, OP_ANDI, OP_ORI: w_next = S_IEX;
          OP_J:                     w_next = S_JEX;
          default: begin
            w_next    = S_FETCH;
            w_ill_set = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        w_wait_st = 1'b1;
        if (i_mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        w_wait_st  = 1'b1;
        if (i_mem_ready) w_next = S_FETCH;
      end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        w_next    = S_RTYPEWB;
        case (i_funct)
          OPW'(6'b100000): w_alucontrol = 3'b010;
          OPW'(6'b100010): w_alucontrol = 3'b110;
          OPW'(6'b100100): w_alucontrol = 3'b000;
          OPW'(6'b100101): w_alucontrol = 3'b001;
          OPW'(6'b101010): w_alucontrol = 3'b111;
          default: begin
            w_next    = S_FETCH;
            w_ill_set = 1'b1;
          end
        endcase
      end
      S_RTYPEWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
        w_next     = S_FETCH;
      end
      S_BEQEX: begin
        w_alusrca    = 1'b1;
        w_alucontrol = 3'b110;
        w_pcsrc      = 2'b01;
        w_pcwrite    = i_zero;
        w_next       = S_FETCH;
      end
      S_IEX: begin
        w_alusrca  = 1'b1;
        w_alusrcb  = 2'b10;
        w_ext_zero = (i_op == OP_ANDI) || (i_op == OP_ORI);
        if (i_op == OP_ANDI)     w_alucontrol = 3'b000;
        else if (i_op == OP_ORI) w_alucontrol = 3'b001;
        w_next = S_IWB;
      end
      S_IWB: begin
        // IR is stable, so re-decoding op reproduces the IEX extension mode
        w_regwrite = 1'b1;
        w_ext_zero = (i_op == OP_ANDI) || (i_op == OP_ORI);
        w_next     = S_FETCH;
      end
      S_JEX: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // abort after WAIT_MAX unready cycles; writes above are already gated by ready
    if (w_wait_st && !i_mem_ready && r_wait == WAIT_LAST) begin
      w_timeout = 1'b1;
      w_next    = S_FETCH;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= S_FETCH;
      r_wait    <= 8'd0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_ill_set;
      r_bus_err <= w_timeout;
      if (w_next != r_state || w_timeout) r_wait <= 8'd0;
      else if (w_wait_st && !i_mem_ready) r_wait <= r_wait + 8'd1;
    end
  end

  assign o_pcwrite    = i_reset_n & w_pcwrite;
  assign o_irwrite    = i_reset_n & w_irwrite;
  assign o_memread    = i_reset_n & w_memread;
  assign o_memwrite   = i_reset_n & w_memwrite;
  assign o_iord       = i_reset_n & w_iord;
  assign o_regwrite   = i_reset_n & w_regwrite;
  assign o_regdst     = i_reset_n & w_regdst;
  assign o_memtoreg   = i_reset_n & w_memtoreg;
  assign o_alusrca    = i_reset_n & w_alusrca;
  assign o_ext_zero   = i_reset_n & w_ext_zero;
  assign o_illegal    = i_reset_n & r_illegal;
  assign o_bus_err    = i_reset_n & r_bus_err;
  assign o_alusrcb    = i_reset_n ? w_alusrcb    : 2'b00;
  assign o_pcsrc      = i_reset_n ? w_pcsrc      : 2'b00;
  assign o_alucontrol = i_reset_n ? w_alucontrol : 3'b000;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class cycle
// by cycle and compares the full control word against hand-built values.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, zero, mem_ready;
  logic [5:0] op, funct;
  logic       pcwrite, irwrite, memread, memwrite, iord, regwrite, regdst;
  logic       memtoreg, alusrca, ext_zero, illegal, bus_err;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  int         n_total = 0;
  int         n_bad   = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.WAIT_MAX(15), .OPW(6)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_op(op), .i_funct(funct),
    .i_zero(zero), .i_mem_ready(mem_ready),
    .o_pcwrite(pcwrite), .o_irwrite(irwrite), .o_memread(memread),
    .o_memwrite(memwrite), .o_iord(iord), .o_regwrite(regwrite),
    .o_regdst(regdst), .o_memtoreg(memtoreg), .o_alusrca(alusrca),
    .o_alusrcb(alusrcb), .o_pcsrc(pcsrc), .o_alucontrol(alucontrol),
    .o_ext_zero(ext_zero), .o_illegal(illegal), .o_bus_err(bus_err)
  );

  // pcw irw mr mw iord rw rd m2r asa asb[2] pcs[2] alu[3] ez ill be
  logic [18:0] w_outs;
  assign w_outs = {pcwrite, irwrite, memread, memwrite, iord, regwrite, regdst,
                   memtoreg, alusrca, alusrcb, pcsrc, alucontrol, ext_zero,
                   illegal, bus_err};

  function automatic logic [18:0] mk(input logic pcw, irw, mr, mw, io, rw, rd, m2r, asa,
                                     input logic [1:0] asb, pcs, input logic [2:0] alu,
                                     input logic ez, ill, be);
    return {pcw, irw, mr, mw, io, rw, rd, m2r, asa, asb, pcs, alu, ez, ill, be};
  endfunction

  localparam logic [18:0] E_ZERO = 19'd0;
  logic [18:0] e_fr, e_fn, e_dec, e_madr, e_mrd, e_mwb, e_mwr, e_rwb, e_jex;

  function automatic logic [18:0] e_rtex(input logic [2:0] alu);
    return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,alu,1'b0,1'b0,1'b0);
  endfunction
  function automatic logic [18:0] e_beq(input logic z);
    return mk(z,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b110,1'b0,1'b0,1'b0);
  endfunction
  function automatic logic [18:0] e_iex(input logic [2:0] alu, input logic ez);
    return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,alu,ez,1'b0,1'b0);
  endfunction
  function automatic logic [18:0] e_iwb(input logic ez);
    return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,3'b010,ez,1'b0,1'b0);
  endfunction

  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [18:0] exp);
    @(negedge clk);
    chk(tag, w_outs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
    mem_ready = 1'b1;
    step("fetch", e_fr);
    step("decode", e_dec);
  endtask

  initial begin
    e_fr   = mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b010,1'b0,1'b0,1'b0);
    e_fn   = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b010,1'b0,1'b0,1'b0);
    e_dec  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b010,1'b0,1'b0,1'b0);
    e_madr = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b010,1'b0,1'b0,1'b0);
    e_mrd  = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b010,1'b0,1'b0,1'b0);
    e_mwb  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,3'b010,1'b0,1'b0,1'b0);
    e_mwr  = mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b010,1'b0,1'b0,1'b0);
    e_rwb  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,3'b010,1'b0,1'b0,1'b0);
    e_jex  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b010,1'b0,1'b0,1'b0);

    reset_n = 1'b0; op = 6'b100011; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    step("rst_a", E_ZERO);
    step("rst_b", E_ZERO);
    reset_n = 1'b1;

    // LW, 5 cycles
    start(6'b100011, 6'd0);
    step("lw_madr", e_madr);
    step("lw_mrd", e_mrd);
    step("lw_mwb", e_mwb);

    // SW, 4 cycles
    start(6'b101011, 6'd0);
    step("sw_madr", e_madr);
    step("sw_mwr", e_mwr);

    // R-type: add, sub, and, or, slt
    start(6'b000000, 6'b100000); step("r_add", e_rtex(3'b010)); step("r_wb", e_rwb);
    start(6'b000000, 6'b100010); step("r_sub", e_rtex(3'b110)); step("r_wb", e_rwb);
    start(6'b000000, 6'b100100); step("r_and", e_rtex(3'b000)); step("r_wb", e_rwb);
    start(6'b000000, 6'b100101); step("r_or",  e_rtex(3'b001)); step("r_wb", e_rwb);
    start(6'b000000, 6'b101010); step("r_slt", e_rtex(3'b111)); step("r_wb", e_rwb);

    // immediates
    start(6'b001101, 6'd0); step("ori_ex", e_iex(3'b001, 1'b1));  step("ori_wb", e_iwb(1'b1));
    start(6'b001000, 6'd0); step("addi_ex", e_iex(3'b010, 1'b0)); step("addi_wb", e_iwb(1'b0));
    start(6'b001100, 6'd0); step("andi_ex", e_iex(3'b000, 1'b1)); step("andi_wb", e_iwb(1'b1));

    // BEQ taken / not taken, J
    zero = 1'b1; start(6'b000100, 6'd0); step("beq_t", e_beq(1'b1));
    zero = 1'b0; start(6'b000100, 6'd0); step("beq_nt", e_beq(1'b0));
    start(6'b000010, 6'd0); step("jex", e_jex);

    // fetch stalled 3 cycles, then completes
    op = 6'b000010; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("fstall", e_fn);
    mem_ready = 1'b1;
    step("fstall_done", e_fr);
    step("fstall_dec", e_dec);
    step("fstall_jex", e_jex);

    // fetch timeout: 15 unready cycles, bus_err in the cycle after, no PC/IR write
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("fto_wait", e_fn);
    step("fto_buserr", e_fn | 19'd1);
    step("fto_clear", e_fn);
    mem_ready = 1'b1;

    // load data stalled 2 cycles in MEMRD
    start(6'b100011, 6'd0);
    step("lws_madr", e_madr);
    mem_ready = 1'b0;
    step("lws_mrd0", e_mrd);
    step("lws_mrd1", e_mrd);
    mem_ready = 1'b1;
    step("lws_mrd2", e_mrd);
    step("lws_mwb", e_mwb);

    // store timeout in MEMWR
    start(6'b101011, 6'd0);
    step("swto_madr", e_madr);
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("swto_wait", e_mwr);
    step("swto_buserr", e_fn | 19'd1);
    mem_ready = 1'b1;
    step("swto_fetch", e_fr);
    op = 6'b000010;
    step("swto_dec", e_dec);
    step("swto_jex", e_jex);

    // illegal opcode
    start(6'b111111, 6'd0);
    op = 6'b000010;
    step("ill_op", e_fr | 19'd2);
    step("ill_op_dec", e_dec);
    step("ill_op_jex", e_jex);

    // illegal funct: no writeback
    start(6'b000000, 6'b000011);
    step("ill_fn_ex", e_rtex(3'b010));
    op = 6'b000010;
    step("ill_fn", e_fr | 19'd2);
    step("ill_fn_dec", e_dec);
    step("ill_fn_jex", e_jex);

    // reset held 2 cycles in the middle of a stalled load
    start(6'b100011, 6'd0);
    step("rmid_madr", e_madr);
    mem_ready = 1'b0;
    step("rmid_mrd", e_mrd);
    reset_n = 1'b0;
    step("rmid_rst0", E_ZERO);
    step("rmid_rst1", E_ZERO);
    reset_n = 1'b1;
    step("rmid_fetch", e_fn);
    mem_ready = 1'b1;
    step("rmid_fetch_r", e_fr);
    step("rmid_dec", e_dec);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
